// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter
// Shares the register-file write port between the ALU, the load/store unit
// and the debug/CSR path. ALU and LSU alternate round-robin. Debug has the
// lowest priority, but after a bounded number of refused cycles it is forced
// through. A single registered stage drives the active-low write port and
// mirrors the in-flight write for hazard detection.
module regs_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int IDX_W        = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [IDX_W-1:0]  alu_idx,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [IDX_W-1:0]  lsu_idx,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  input  logic              dbg_valid,
  input  logic [IDX_W-1:0]  dbg_idx,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ready,
  output logic              wen_o,
  output logic [IDX_W-1:0]  rd_idx_o,
  output logic [DATA_W-1:0] rd_wdata_o,
  output logic [IDX_W-1:0]  pend_idx_o,
  output logic              pend_valid_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // last_rr: 0 means the ALU won the most recent ALU/LSU grant, 1 means the LSU did
  logic              last_rr;
  logic [3:0]        starve_cnt;
  logic              force_dbg;
  logic              alu_gnt;
  logic              lsu_gnt;
  logic              dbg_gnt;
  logic              xfer;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] sel_data;

  assign force_dbg = (starve_cnt == LIMIT);

  // Pick at most one requester per cycle; a starved debug request preempts everyone
  always_comb begin
    alu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (rst_n) begin
      if (force_dbg && dbg_valid) begin
        dbg_gnt = 1'b1;
      end else if (alu_valid && lsu_valid) begin
        if (last_rr) alu_gnt = 1'b1;
        else         lsu_gnt = 1'b1;
      end else if (alu_valid) begin
        alu_gnt = 1'b1;
      end else if (lsu_valid) begin
        lsu_gnt = 1'b1;
      end else if (dbg_valid) begin
        dbg_gnt = 1'b1;
      end
    end
  end

  assign alu_ready = alu_gnt;
  assign lsu_ready = lsu_gnt;
  assign dbg_ready = dbg_gnt;
  assign xfer      = alu_gnt | lsu_gnt | dbg_gnt;

  // Steer the granted requester's index and data toward the output register
  always_comb begin
    sel_idx  = '0;
    sel_data = '0;
    if (alu_gnt) begin
      sel_idx  = alu_idx;
      sel_data = alu_data;
    end else if (lsu_gnt) begin
      sel_idx  = lsu_idx;
      sel_data = lsu_data;
    end else if (dbg_gnt) begin
      sel_idx  = dbg_idx;
      sel_data = dbg_data;
    end
  end

  // Round-robin history and debug starvation counter; forced debug grants leave the rr order alone
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_rr    <= 1'b1;
      starve_cnt <= 4'd0;
    end else begin
      if (alu_gnt)      last_rr <= 1'b0;
      else if (lsu_gnt) last_rr <= 1'b1;

      if (!dbg_valid || dbg_gnt) starve_cnt <= 4'd0;
      else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Output register: writes to x0 are accepted upstream but never reach the register file
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_o      <= 1'b1;
      rd_idx_o   <= '0;
      rd_wdata_o <= '0;
    end else if (xfer && (sel_idx != '0)) begin
      wen_o      <= 1'b0;
      rd_idx_o   <= sel_idx;
      rd_wdata_o <= sel_data;
    end else begin
      wen_o      <= 1'b1;
    end
  end

  assign pend_idx_o   = rd_idx_o;
  assign pend_valid_o = ~wen_o;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// tb_regs_wb_arbiter
// Drives one cycle at a time, predicts the ready pattern and the resulting
// register-file write with a small reference model, and compares the write
// port one cycle later through a scoreboard queue.
module tb_regs_wb_arbiter;

  localparam int DATA_W       = 32;
  localparam int IDX_W        = 5;
  localparam int STARVE_LIMIT = 4;

  logic              clk;
  logic              rst_n;
  logic              alu_valid, lsu_valid, dbg_valid;
  logic [IDX_W-1:0]  alu_idx, lsu_idx, dbg_idx;
  logic [DATA_W-1:0] alu_data, lsu_data, dbg_data;
  logic              alu_ready, lsu_ready, dbg_ready;
  logic              wen_o;
  logic [IDX_W-1:0]  rd_idx_o;
  logic [DATA_W-1:0] rd_wdata_o;
  logic [IDX_W-1:0]  pend_idx_o;
  logic              pend_valid_o;

  typedef struct {
    logic              wen;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic m_last_rr;
  int   m_cnt;
  logic [2:0] got;

  regs_wb_arbiter #(
    .DATA_W(DATA_W),
    .IDX_W(IDX_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .alu_valid(alu_valid),
    .alu_idx(alu_idx),
    .alu_data(alu_data),
    .alu_ready(alu_ready),
    .lsu_valid(lsu_valid),
    .lsu_idx(lsu_idx),
    .lsu_data(lsu_data),
    .lsu_ready(lsu_ready),
    .dbg_valid(dbg_valid),
    .dbg_idx(dbg_idx),
    .dbg_data(dbg_data),
    .dbg_ready(dbg_ready),
    .wen_o(wen_o),
    .rd_idx_o(rd_idx_o),
    .rd_wdata_o(rd_wdata_o),
    .pend_idx_o(pend_idx_o),
    .pend_valid_o(pend_valid_o)
  );

  // Free-running 10ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // One cycle: drive at posedge+1, compare at negedge, optionally pull reset before the next edge
  task automatic applyStimulus(
    input  logic              rst,
    input  logic              drop,
    input  logic              av, input logic [IDX_W-1:0] ai, input logic [DATA_W-1:0] ad,
    input  logic              lv, input logic [IDX_W-1:0] li, input logic [DATA_W-1:0] ld,
    input  logic              dv, input logic [IDX_W-1:0] di, input logic [DATA_W-1:0] dd,
    output logic [2:0]        obs
  );
    wr_t        e;
    wr_t        n;
    logic [2:0] exp_rdy;
    rst_n     = rst;
    alu_valid = av; alu_idx = ai; alu_data = ad;
    lsu_valid = lv; lsu_idx = li; lsu_data = ld;
    dbg_valid = dv; dbg_idx = di; dbg_data = dd;
    @(negedge clk);

    if (exp_q.size() == 0) begin
      checkOutput("sb_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      checkOutput("wen", {63'd0, wen_o}, {63'd0, e.wen});
      checkOutput("pend_valid", {63'd0, pend_valid_o}, {63'd0, ~e.wen});
      if (!e.wen) begin
        checkOutput("rd_idx", 64'(rd_idx_o), 64'(e.idx));
        checkOutput("rd_wdata", 64'(rd_wdata_o), 64'(e.data));
        checkOutput("pend_idx", 64'(pend_idx_o), 64'(e.idx));
      end
    end

    exp_rdy = 3'b000;
    if (rst) begin
      if ((m_cnt == STARVE_LIMIT) && dv) exp_rdy = 3'b001;
      else if (av && lv)                 exp_rdy = m_last_rr ? 3'b100 : 3'b010;
      else if (av)                       exp_rdy = 3'b100;
      else if (lv)                       exp_rdy = 3'b010;
      else if (dv)                       exp_rdy = 3'b001;
    end
    obs = {alu_ready, lsu_ready, dbg_ready};
    checkOutput("ready", 64'(obs), 64'(exp_rdy));

    if (drop) rst_n = 1'b0;
    n.wen  = 1'b1;
    n.idx  = '0;
    n.data = '0;
    if (!rst || drop) begin
      m_last_rr = 1'b1;
      m_cnt     = 0;
    end else begin
      if (exp_rdy[2])      m_last_rr = 1'b0;
      else if (exp_rdy[1]) m_last_rr = 1'b1;
      if (!dv || exp_rdy[0])          m_cnt = 0;
      else if (m_cnt < STARVE_LIMIT)  m_cnt++;
      if (exp_rdy[2] && ai != '0) begin n.wen = 1'b0; n.idx = ai; n.data = ad; end
      if (exp_rdy[1] && li != '0) begin n.wen = 1'b0; n.idx = li; n.data = ld; end
      if (exp_rdy[0] && di != '0) begin n.wen = 1'b0; n.idx = di; n.data = dd; end
    end
    exp_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    logic [2:0] o;
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, o);
  endtask

  task automatic resetCycle();
    logic [2:0] o;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, o);
  endtask

  // Directed scenarios, each checked by the model plus a few hard-coded expectations
  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_idx = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_idx = '0; lsu_data = '0;
    dbg_valid = 1'b0; dbg_idx = '0; dbg_data = '0;
    m_last_rr = 1'b1;
    m_cnt     = 0;
    @(posedge clk);
    #1;
    checkOutput("rst_wen", {63'd0, wen_o}, 64'd1);
    checkOutput("rst_idx", 64'(rd_idx_o), 64'd0);
    checkOutput("rst_wdata", 64'(rd_wdata_o), 64'd0);
    checkOutput("rst_pend_valid", {63'd0, pend_valid_o}, 64'd0);
    exp_q.push_back('{wen: 1'b1, idx: '0, data: '0});
    resetCycle();
    idleCycles(1);

    $display("[TB] single alu write");
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, '0, '0, got);
    checkOutput("tp1_ready", 64'(got), 64'b100);
    checkOutput("tp1_wen", {63'd0, wen_o}, 64'd0);
    checkOutput("tp1_idx", 64'(rd_idx_o), 64'd3);
    checkOutput("tp1_wdata", 64'(rd_wdata_o), 64'hDEAD_BEEF);
    idleCycles(1);
    checkOutput("tp1_wen_after", {63'd0, wen_o}, 64'd1);

    $display("[TB] alu/lsu round-robin after reset");
    resetCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_0A00 + 32'(i), 1'b1, 5'd6, 32'h0000_0B00 + 32'(i),
                    1'b0, '0, '0, got);
      checkOutput("tp2_grant", 64'(got), (i % 2 == 0) ? 64'b100 : 64'b010);
      checkOutput("tp2_idx", 64'(rd_idx_o), (i % 2 == 0) ? 64'd5 : 64'd6);
    end
    idleCycles(1);

    $display("[TB] x0 write filtered");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 1'b0, '0, '0, got);
    checkOutput("tp3_ready", 64'(got), 64'b010);
    checkOutput("tp3_wen", {63'd0, wen_o}, 64'd1);
    checkOutput("tp3_pend_valid", {63'd0, pend_valid_o}, 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd8, 32'h8888, 1'b1, 5'd9, 32'h9999, 1'b0, '0, '0, got);
    checkOutput("tp3_tie", 64'(got), 64'b100);
    idleCycles(1);

    $display("[TB] debug starvation guard");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 5'd1, 32'h1111_0000 + 32'(i), 1'b1, 5'd2, 32'h2222_0000 + 32'(i),
                    1'b1, 5'd15, 32'h5A5A_5A5A, got);
      checkOutput("tp4_grant", 64'(got),
                  (i % 5 == 4) ? 64'b001 : ((i % 5) % 2 == 0) ? 64'b010 : 64'b100);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b0, '0, '0, got);
    checkOutput("tp4_resume", 64'(got), 64'b010);
    idleCycles(1);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd7, 32'h7777_7777, 1'b0, '0, '0, 1'b0, '0, '0, got);
    checkOutput("tp5_accept", 64'(got), 64'b100);
    checkOutput("tp5_wen_dropped", {63'd0, wen_o}, 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd7, 32'h7777_7777, 1'b1, 5'd4, 32'h4444, 1'b1, 5'd9, 32'h9, got);
    checkOutput("tp5_ready_in_reset", 64'(got), 64'b000);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd11, 32'hBBBB, 1'b1, 5'd12, 32'hCCCC, 1'b0, '0, '0, got);
    checkOutput("tp5_first_tie", 64'(got), 64'b100);
    checkOutput("tp5_idx", 64'(rd_idx_o), 64'd11);
    idleCycles(1);

    $display("[TB] lone debug write");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd10, 32'hCAFE_0001, got);
    checkOutput("tp6_ready", 64'(got), 64'b001);
    checkOutput("tp6_wen", {63'd0, wen_o}, 64'd0);
    checkOutput("tp6_idx", 64'(rd_idx_o), 64'd10);
    checkOutput("tp6_wdata", 64'(rd_wdata_o), 64'hCAFE_0001);
    idleCycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
